// File: rtl/rnn_engine.sv
// rnn_engine: time-multiplexed fixed-point (Q16.16) recurrent inference engine.
// Each frame latches 42 features, then evaluates 23 rows (22 gains + VAD).
// Every row is a 42-term dot product, plus one recurrent term, plus a bias,
// followed by a saturating hard sigmoid. A single MAC and a weight RAM are
// shared across all rows. One frame takes 1014 cycles: LATCH, 23*44 MAC
// cycles, then PUBLISH.
// Optional build macro RNN_RECURRENT_EN enables the recurrent (column 42)
// term. When it is undefined, that cycle still elapses but contributes zero.
module rnn_engine #(
    parameter int FIXED = 32,
    parameter int FRAC  = 16,
    parameter int N_IN  = 42,
    parameter int N_OUT = 22
) (
    output logic [N_OUT*FIXED-1:0] gains,
    output logic [FIXED-1:0]       vad,
    input  logic [N_IN*FIXED-1:0]  feature,
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   w_we,
    input  logic [9:0]             w_addr,
    input  logic [FIXED-1:0]       w_data,
    output logic                   done
);

    localparam int N_ROWS    = N_OUT + 1;
    localparam int N_COLS    = N_IN + 2;
    localparam int RAM_WORDS = N_ROWS * N_COLS;
    localparam int ACC_W     = 48;

    localparam logic [5:0] LAST_COL = 6'(N_COLS - 1);
    localparam logic [5:0] REC_COL  = 6'(N_IN);
    localparam logic [4:0] LAST_ROW = 5'(N_ROWS - 1);

    localparam logic [1:0] LATCH   = 2'd0;
    localparam logic [1:0] MAC     = 2'd1;
    localparam logic [1:0] PUBLISH = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_HI = 48'sh0000_7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] SAT_LO = 48'shFFFF_8000_0000;
    localparam logic signed [FIXED:0]   HALF   = 33'sh0_0000_8000;
    localparam logic signed [FIXED:0]   ONE    = 33'sh0_0001_0000;

    logic [1:0]              state;
    logic [4:0]              row;
    logic [5:0]              col;
    logic signed [ACC_W-1:0] acc;

    logic signed [FIXED-1:0] wram   [RAM_WORDS];
    logic signed [FIXED-1:0] x_lat  [N_IN];
    logic signed [FIXED-1:0] shadow [N_ROWS];
    logic signed [FIXED-1:0] gains_q [N_OUT];
    logic signed [FIXED-1:0] vad_q;

    logic [9:0]              rd_addr;
    logic signed [FIXED-1:0] w_rd;
    logic signed [FIXED-1:0] operand;
    logic signed [63:0]      prod;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [FIXED-1:0] row_result;

    // Clamp the wide accumulator into the signed 32-bit Q16.16 range.
    function automatic logic signed [FIXED-1:0] sat_fixed(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) begin
            return 32'sh7FFF_FFFF;
        end else if (v < SAT_LO) begin
            return 32'sh8000_0000;
        end else begin
            return FIXED'(v);
        end
    endfunction

    // Hard sigmoid: s/4 + 0.5, clamped to [0.0, 1.0]; one guard bit avoids overflow.
    function automatic logic signed [FIXED-1:0] hard_sigmoid(input logic signed [FIXED-1:0] s);
        logic signed [FIXED:0] t;
        t = ($signed({s[FIXED-1], s}) >>> 2) + HALF;
        if (t < 0) begin
            return '0;
        end else if (t > ONE) begin
            return FIXED'(ONE);
        end else begin
            return FIXED'(t);
        end
    endfunction

    // Weight RAM write port: independent of reset and engine state.
    always_ff @(posedge clk) begin
        if (w_we && (w_addr < 10'(RAM_WORDS))) begin
            wram[w_addr] <= w_data;
        end
    end

    // Datapath for the current (row, col): weight fetch, operand select, scaled product.
    always_comb begin
        rd_addr = 10'(row) * 10'(N_COLS) + 10'(col);
        w_rd    = wram[rd_addr];
        operand = '0;
        if (col < REC_COL) begin
            operand = x_lat[col];
        end
`ifdef RNN_RECURRENT_EN
        else if (col == REC_COL) begin
            operand = (row < 5'(N_OUT)) ? gains_q[row] : vad_q;
        end
`endif
        prod       = $signed({{32{w_rd[FIXED-1]}}, w_rd}) * $signed({{32{operand[FIXED-1]}}, operand});
        term       = ACC_W'(prod >>> FRAC);
        bias_ext   = $signed({{(ACC_W-FIXED){w_rd[FIXED-1]}}, w_rd});
        row_result = hard_sigmoid(sat_fixed(acc + bias_ext));
    end

    // Sequencer: LATCH -> MAC over all rows/columns -> PUBLISH, plus accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LATCH;
            row   <= '0;
            col   <= '0;
            acc   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LATCH: begin
                    row   <= '0;
                    col   <= '0;
                    acc   <= '0;
                    state <= MAC;
                end
                MAC: begin
                    if (col == LAST_COL) begin
                        acc <= '0;
                        col <= '0;
                        if (row == LAST_ROW) begin
                            row   <= '0;
                            state <= PUBLISH;
                        end else begin
                            row <= row + 5'd1;
                        end
                    end else begin
                        acc <= acc + term;
                        col <= col + 6'd1;
                    end
                end
                PUBLISH: begin
                    done  <= 1'b1;
                    state <= LATCH;
                end
                default: begin
                    state <= LATCH;
                end
            endcase
        end
    end

    // Feature capture: sampled only in LATCH so mid-frame input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                x_lat[i] <= '0;
            end
        end else if (state == LATCH) begin
            for (int i = 0; i < N_IN; i++) begin
                x_lat[i] <= $signed(feature[i*FIXED +: FIXED]);
            end
        end
    end

    // Shadow results: a row's activation lands here when its bias column completes.
    always_ff @(posedge clk) begin
        if (state == MAC && col == LAST_COL) begin
            shadow[row] <= row_result;
        end
    end

    // Published outputs: updated only in PUBLISH, so partial frames never appear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                gains_q[j] <= '0;
            end
            vad_q <= '0;
        end else if (state == PUBLISH) begin
            for (int j = 0; j < N_OUT; j++) begin
                gains_q[j] <= shadow[j];
            end
            vad_q <= shadow[N_OUT];
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_pack
        assign gains[j*FIXED +: FIXED] = gains_q[j];
    end
    assign vad = vad_q;

endmodule

// File: tb/tb_rnn_engine.sv
// Directed testbench for rnn_engine: frame timing, dot product, saturation,
// clamping, recurrence, mid-frame reset and feature latching.
module tb_rnn_engine;

    localparam int N_IN  = 42;
    localparam int N_OUT = 22;
    localparam int COLS  = 44;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  w_we = 1'b0;
    logic [9:0]            w_addr = '0;
    logic [31:0]           w_data = '0;
    logic [N_IN*32-1:0]    feature = '0;
    logic [N_OUT*32-1:0]   gains;
    logic [31:0]           vad;
    logic                  done;

    int total = 0;
    int bad   = 0;

    rnn_engine dut (
        .gains  (gains),
        .vad    (vad),
        .feature(feature),
        .clk    (clk),
        .rst_n  (rst_n),
        .w_we   (w_we),
        .w_addr (w_addr),
        .w_data (w_data),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        w_we   = 1'b1;
        w_addr = 10'(a);
        w_data = d;
        tick();
        w_we   = 1'b0;
    endtask

    // Returns the number of edges until done is seen, or 0 on timeout.
    task automatic wait_done(output int n);
        n = 0;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (done === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic restart();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N_IN; i++) feature[i*32 +: 32] = 32'h0003_0000 + 32'(i);
        w_we = 1'b1;
        for (int a = 0; a < 1012; a++) begin
            w_addr = 10'(a);
            w_data = '0;
            tick();
        end
        w_we = 1'b0;
        tick();
        total++; if (gains !== '0) begin bad++; $display("FAIL reset_gains got=%h want=0", gains); end
        total++; if (vad !== 32'h0) begin bad++; $display("FAIL reset_vad got=%h want=0", vad); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    endtask

    task automatic test_zero_weights();
        int n;
        rst_n = 1'b1;
        wait_done(n);
        total++; if (n != 1014) begin bad++; $display("FAIL first_done_edge got=%0d want=1014", n); end
        total++; if (gains !== {N_OUT{32'h0000_8000}}) begin bad++; $display("FAIL zero_gains got=%h want=all 00008000", gains); end
        total++; if (vad !== 32'h0000_8000) begin bad++; $display("FAIL zero_vad got=%h want=00008000", vad); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_width got=%b want=0", done); end
        wait_done(n);
        total++; if (n != 1013) begin bad++; $display("FAIL frame_period got=%0d want=1013 after pulse", n); end
    endtask

    task automatic test_diagonal();
        int n;
        logic [N_OUT*32-1:0] exp_g;
        for (int j = 0; j < N_OUT; j++) begin
            wr(j*COLS + j, 32'h0001_0000);
            feature[j*32 +: 32] = 32'h0002_0000;
            exp_g[j*32 +: 32]   = 32'h0001_0000;
        end
        for (int i = N_OUT; i < N_IN; i++) feature[i*32 +: 32] = 32'h0BAD_0000;
        // -2.0 -> 0; +1.0 -> 0.75; -1/65536 floors to -1 -> 0x7FFF
        feature[1*32 +: 32] = 32'hFFFE_0000; exp_g[1*32 +: 32] = 32'h0000_0000;
        feature[2*32 +: 32] = 32'h0001_0000; exp_g[2*32 +: 32] = 32'h0000_C000;
        wr(3*COLS + 3, 32'h0000_0001);
        feature[3*32 +: 32] = 32'hFFFF_0000; exp_g[3*32 +: 32] = 32'h0000_7FFF;
        // large positive / negative products must saturate before the sigmoid
        wr(4*COLS + 4, 32'h7FFF_FFFF);
        feature[4*32 +: 32] = 32'h7FFF_FFFF; exp_g[4*32 +: 32] = 32'h0001_0000;
        wr(5*COLS + 5, 32'h8000_0000);
        feature[5*32 +: 32] = 32'h7FFF_FFFF; exp_g[5*32 +: 32] = 32'h0000_0000;
        restart();
        wait_done(n);
        total++; if (n != 1014) begin bad++; $display("FAIL diag_edge got=%0d want=1014", n); end
        total++; if (gains !== exp_g) begin bad++; $display("FAIL diag_gains got=%h want=%h", gains, exp_g); end
        total++; if (vad !== 32'h0000_8000) begin bad++; $display("FAIL diag_vad got=%h want=00008000", vad); end
        for (int j = 0; j < N_OUT; j++) wr(j*COLS + j, 32'h0);
    endtask

    task automatic test_bias();
        int n;
        for (int r = 0; r <= N_OUT; r++) wr(r*COLS + 43, 32'hFFFC_0000);
        restart();
        wait_done(n);
        total++; if (gains !== '0) begin bad++; $display("FAIL bias_neg_gains got=%h want=0", gains); end
        total++; if (vad !== 32'h0) begin bad++; $display("FAIL bias_neg_vad got=%h want=0", vad); end
        for (int r = 0; r <= N_OUT; r++) wr(r*COLS + 43, 32'h0004_0000);
        restart();
        wait_done(n);
        total++; if (gains !== {N_OUT{32'h0001_0000}}) begin bad++; $display("FAIL bias_pos_gains got=%h want=all 00010000", gains); end
        total++; if (vad !== 32'h0001_0000) begin bad++; $display("FAIL bias_pos_vad got=%h want=00010000", vad); end
        for (int r = 0; r <= N_OUT; r++) wr(r*COLS + 43, 32'h0);
    endtask

    task automatic test_recurrent();
        int n;
        logic [31:0] exp2;
`ifdef RNN_RECURRENT_EN
        exp2 = 32'h0000_A000;
`else
        exp2 = 32'h0000_8000;
`endif
        for (int r = 0; r <= N_OUT; r++) wr(r*COLS + 42, 32'h0001_0000);
        restart();
        wait_done(n);
        total++; if (gains !== {N_OUT{32'h0000_8000}}) begin bad++; $display("FAIL rec_f1_gains got=%h want=all 00008000", gains); end
        total++; if (vad !== 32'h0000_8000) begin bad++; $display("FAIL rec_f1_vad got=%h want=00008000", vad); end
        wait_done(n);
        total++; if (n != 1014) begin bad++; $display("FAIL rec_period got=%0d want=1014", n); end
        total++; if (gains !== {N_OUT{exp2}}) begin bad++; $display("FAIL rec_f2_gains got=%h want=all %h", gains, exp2); end
        total++; if (vad !== exp2) begin bad++; $display("FAIL rec_f2_vad got=%h want=%h", vad, exp2); end
    endtask

    task automatic test_mid_reset();
        int n;
        restart();
        wait_done(n);
        repeat (500) tick();
        rst_n = 1'b0;
        tick();
        total++; if (gains !== '0) begin bad++; $display("FAIL midrst_gains got=%h want=0", gains); end
        total++; if (vad !== 32'h0) begin bad++; $display("FAIL midrst_vad got=%h want=0", vad); end
        rst_n = 1'b1;
        wait_done(n);
        total++; if (n != 1014) begin bad++; $display("FAIL midrst_edge got=%0d want=1014", n); end
        total++; if (gains !== {N_OUT{32'h0000_8000}}) begin bad++; $display("FAIL midrst_gains2 got=%h want=all 00008000", gains); end
        total++; if (vad !== 32'h0000_8000) begin bad++; $display("FAIL midrst_vad2 got=%h want=00008000", vad); end
        for (int r = 0; r <= N_OUT; r++) wr(r*COLS + 42, 32'h0);
    endtask

    task automatic test_feature_latch();
        int n;
        for (int j = 0; j < N_OUT; j++) wr(j*COLS + j, 32'h0001_0000);
        wr(N_OUT*COLS + 0, 32'h0001_0000);
        for (int i = 0; i < N_IN; i++) feature[i*32 +: 32] = 32'h0002_0000;
        restart();
        repeat (300) tick();
        for (int i = 0; i < N_IN; i++) feature[i*32 +: 32] = 32'hFFFE_0000;
        wait_done(n);
        total++; if (n != 714) begin bad++; $display("FAIL latch_edge got=%0d want=714", n); end
        total++; if (gains !== {N_OUT{32'h0001_0000}}) begin bad++; $display("FAIL latch_old_gains got=%h want=all 00010000", gains); end
        total++; if (vad !== 32'h0001_0000) begin bad++; $display("FAIL latch_old_vad got=%h want=00010000", vad); end
        wait_done(n);
        total++; if (gains !== '0) begin bad++; $display("FAIL latch_new_gains got=%h want=0", gains); end
        total++; if (vad !== 32'h0) begin bad++; $display("FAIL latch_new_vad got=%h want=0", vad); end
    endtask

    initial begin
        test_reset();
        test_zero_weights();
        test_diagonal();
        test_bias();
        test_recurrent();
        test_mid_reset();
        test_feature_latch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
